// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for a classic five-stage pipeline.
// It handles load-use stalls, branch flushes and halt/drain/resume, and counts the stall cycles.
module pipeline_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rt,
    input  logic             branch_taken,
    input  logic             halt_inst,
    input  logic             resume,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    // The counter holds the remaining cycles of a multi-cycle sequence, excluding the RUN
    // cycle that started it.
    localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0]       DRAIN_INIT = 3'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [2:0]       seq_cnt_q, seq_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_use;

    // A load to r0 never creates a hazard, because r0 is hard-wired to zero.
    assign load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                      ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            seq_cnt_q   <= 3'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            seq_cnt_q   <= seq_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        seq_cnt_d    = seq_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        halted       = 1'b0;

        unique case (state_q)
            RUN: begin
                if (load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (stall_cnt_q != CNT_MAX) begin
                        stall_cnt_d = stall_cnt_q + CNT_ONE;
                    end
                end else if (branch_taken) begin
                    if_id_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d   = FLUSH;
                        seq_cnt_d = FLUSH_INIT;
                    end
                end else if (halt_inst) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (DRAIN_CYCLES > 1) begin
                        state_d   = DRAIN;
                        seq_cnt_d = DRAIN_INIT;
                    end else begin
                        state_d = HALTED;
                    end
                end
            end

            FLUSH: begin
                if_id_flush = 1'b1;
                seq_cnt_d   = seq_cnt_q - 3'd1;
                if (seq_cnt_q == 3'd1) begin
                    state_d = RUN;
                end
            end

            DRAIN: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                seq_cnt_d    = seq_cnt_q - 3'd1;
                if (seq_cnt_q == 3'd1) begin
                    state_d = HALTED;
                end
            end

            HALTED: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                halted       = 1'b1;
                if (resume) begin
                    state_d   = RUN;
                    seq_cnt_d = 3'd0;
                end
            end

            default: begin
                state_d   = RUN;
                seq_cnt_d = 3'd0;
            end
        endcase
    end

    assign stall_cnt = stall_cnt_q;

endmodule
